// File: rtl/hitbox_collision_unit.sv
// Multi-obstacle AABB collision detector: damage pulse, invulnerability window, hit stats.
// Optional immunity blink output enabled by defining COLLISION_BLINK_EN.
module hitbox_collision_unit #(
    parameter int N_OBST        = 4,
    parameter int PLAYER_W      = 16,
    parameter int PLAYER_H      = 16,
    parameter int OBST_W        = 16,
    parameter int OBST_H        = 16,
    parameter int IMMUNE_CYCLES = 108000000,
    parameter int CNT_W         = 28,
    parameter int BLINK_SHIFT   = 22
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic [12*N_OBST-1:0]  obstacle_x_in,
    input  logic [12*N_OBST-1:0]  obstacle_y_in,
    input  logic [N_OBST-1:0]     obstacle_valid_in,
    input  logic [11:0]           mouse_x_in,
    input  logic [11:0]           mouse_y_in,
    output logic                  damage_out,
    output logic                  immune_out,
    output logic [3:0]            hit_id_out,
    output logic [7:0]            hit_count_out,
    output logic                  blink_out
);

    localparam logic [12:0]      PLAYER_W13 = 13'(PLAYER_W);
    localparam logic [12:0]      PLAYER_H13 = 13'(PLAYER_H);
    localparam logic [12:0]      OBST_W13   = 13'(OBST_W);
    localparam logic [12:0]      OBST_H13   = 13'(OBST_H);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IMMUNE_CYCLES - 1);

    if (BLINK_SHIFT >= CNT_W) begin : g_bad_blink_shift
        $error("BLINK_SHIFT must index a bit of the immunity counter");
    end

    typedef enum logic [1:0] {IDLE, CHECK, IMMUNE} state_t;

    // Stage 1: input registers
    logic                 enable_q;
    logic [12*N_OBST-1:0] obst_x_q;
    logic [12*N_OBST-1:0] obst_y_q;
    logic [N_OBST-1:0]    obst_v_q;
    logic [11:0]          mouse_x_q;
    logic [11:0]          mouse_y_q;

    // NOTE: every register uses non-blocking assignment so all stages sample pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            enable_q  <= 1'b0;
            obst_x_q  <= '0;
            obst_y_q  <= '0;
            obst_v_q  <= '0;
            mouse_x_q <= '0;
            mouse_y_q <= '0;
        end else begin
            enable_q  <= enable_in;
            obst_x_q  <= obstacle_x_in;
            obst_y_q  <= obstacle_y_in;
            obst_v_q  <= obstacle_valid_in;
            mouse_x_q <= mouse_x_in;
            mouse_y_q <= mouse_y_in;
        end
    end

    // Stage 2: per-channel overlap, sums widened to 13 bits so edge-of-screen boxes cannot wrap
    logic [12:0]       px;
    logic [12:0]       py;
    logic [N_OBST-1:0] overlap_d;
    logic [N_OBST-1:0] overlap_q;

    assign px = {1'b0, mouse_x_q};
    assign py = {1'b0, mouse_y_q};

    // NOTE: combinational outputs get a default before the loop so no latch is inferred.
    always_comb begin
        overlap_d = '0;
        for (int i = 0; i < N_OBST; i++) begin
            overlap_d[i] = obst_v_q[i]
                && (px < {1'b0, obst_x_q[12*i +: 12]} + OBST_W13)
                && ({1'b0, obst_x_q[12*i +: 12]} < px + PLAYER_W13)
                && (py < {1'b0, obst_y_q[12*i +: 12]} + OBST_H13)
                && ({1'b0, obst_y_q[12*i +: 12]} < py + PLAYER_H13);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) overlap_q <= '0;
        else     overlap_q <= overlap_d;
    end

    // Lowest set index wins on simultaneous contact
    logic [3:0] first_id;
    logic       any_hit;

    always_comb begin
        first_id = '0;
        for (int i = N_OBST - 1; i >= 0; i--) begin
            if (overlap_q[i]) first_id = 4'(i);
        end
    end

    assign any_hit = |overlap_q;

    // Stage 3: control FSM with registered outputs
    state_t           state;
    logic [CNT_W-1:0] counter;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state         <= IDLE;
            counter       <= '0;
            damage_out    <= 1'b0;
            immune_out    <= 1'b0;
            hit_id_out    <= '0;
            hit_count_out <= '0;
`ifdef COLLISION_BLINK_EN
            blink_out     <= 1'b0;
`endif
        end else begin
            damage_out <= 1'b0;
            case (state)
                IDLE: begin
                    counter    <= '0;
                    immune_out <= 1'b0;
`ifdef COLLISION_BLINK_EN
                    blink_out  <= 1'b0;
`endif
                    if (enable_q) state <= CHECK;
                end
                CHECK: begin
                    if (!enable_q) begin
                        state <= IDLE;
                    end else if (any_hit) begin
                        damage_out <= 1'b1;
                        hit_id_out <= first_id;
                        if (hit_count_out != 8'hFF) hit_count_out <= hit_count_out + 8'd1;
                        counter    <= '0;
                        immune_out <= 1'b1;
`ifdef COLLISION_BLINK_EN
                        blink_out  <= 1'b1;
`endif
                        state      <= IMMUNE;
                    end
                end
                IMMUNE: begin
                    if (!enable_q || counter == CNT_LAST) begin
                        counter    <= '0;
                        immune_out <= 1'b0;
`ifdef COLLISION_BLINK_EN
                        blink_out  <= 1'b0;
`endif
                        state      <= enable_q ? CHECK : IDLE;
                    end else begin
                        counter   <= counter + 1'b1;
`ifdef COLLISION_BLINK_EN
                        // Blink phase follows the post-increment counter so entry starts high
                        blink_out <= ~(counter + 1'b1) >> BLINK_SHIFT;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef COLLISION_BLINK_EN
    assign blink_out = 1'b0;
`endif

endmodule

// File: tb/tb_hitbox_collision_unit.sv
// Scoreboard bench for hitbox_collision_unit (IMMUNE_CYCLES=100, BLINK_SHIFT=3).
// Expected pulses are queued when stimulus is driven and matched by a pulse monitor.
module tb_hitbox_collision_unit;

    localparam int N     = 4;
    localparam int IMM   = 100;
    localparam int BSH   = 3;

    typedef struct {
        int       cyc;
        int       id;
        int       count;
    } exp_t;

    logic              pclk = 1'b0;
    logic              rst;
    logic              enable_in;
    logic [12*N-1:0]   obstacle_x_in;
    logic [12*N-1:0]   obstacle_y_in;
    logic [N-1:0]      obstacle_valid_in;
    logic [11:0]       mouse_x_in;
    logic [11:0]       mouse_y_in;
    logic              damage_out;
    logic              immune_out;
    logic [3:0]        hit_id_out;
    logic [7:0]        hit_count_out;
    logic              blink_out;

    logic [11:0] ox [N];
    logic [11:0] oy [N];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    exp_t sb_q[$];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            obstacle_x_in[12*i +: 12] = ox[i];
            obstacle_y_in[12*i +: 12] = oy[i];
        end
    end

    hitbox_collision_unit #(
        .N_OBST(N), .PLAYER_W(16), .PLAYER_H(16), .OBST_W(16), .OBST_H(16),
        .IMMUNE_CYCLES(IMM), .CNT_W(8), .BLINK_SHIFT(BSH)
    ) dut (
        .pclk(pclk), .rst(rst), .enable_in(enable_in),
        .obstacle_x_in(obstacle_x_in), .obstacle_y_in(obstacle_y_in),
        .obstacle_valid_in(obstacle_valid_in),
        .mouse_x_in(mouse_x_in), .mouse_y_in(mouse_y_in),
        .damage_out(damage_out), .immune_out(immune_out),
        .hit_id_out(hit_id_out), .hit_count_out(hit_count_out),
        .blink_out(blink_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic set_obst(input int ch, input int x, input int y, input logic v);
        ox[ch] = 12'(x);
        oy[ch] = 12'(y);
        obstacle_valid_in[ch] = v;
    endtask

    // Queue a hit expected 3 cycles after the current sample point, plus `offset` cycles
    task automatic expect_hit(input int offset, input int id);
        exp_t e;
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        e.cyc   = cyc + 3 + offset;
        e.id    = id;
        e.count = exp_count;
        sb_q.push_back(e);
    endtask

    // Pulse monitor: compares every damage pulse against the head of the scoreboard
    always @(posedge pclk) begin
        #1;
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
            check("missed_pulse", 32'(cyc), 32'(sb_q[0].cyc));
            void'(sb_q.pop_front());
        end
        if (damage_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_hit_id", 32'(hit_id_out), 32'(e.id));
                check("pulse_hit_count", 32'(hit_count_out), 32'(e.count));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic exp_blink;

        rst = 1'b1;
        enable_in = 1'b0;
        mouse_x_in = 12'd100;
        mouse_y_in = 12'd100;
        obstacle_valid_in = '0;
        for (int i = 0; i < N; i++) begin
            ox[i] = '0;
            oy[i] = '0;
        end
        tick(3);
        check("rst_damage", 32'(damage_out), 0);
        check("rst_immune", 32'(immune_out), 0);
        check("rst_hit_id", 32'(hit_id_out), 0);
        check("rst_hit_count", 32'(hit_count_out), 0);
        check("rst_blink", 32'(blink_out), 0);

        rst = 1'b0;
        enable_in = 1'b1;
        tick(4);

        // 1: basic overlap, one pulse and a 100-cycle window
        set_obst(0, 110, 108, 1'b1);
        expect_hit(0, 0);
        tick(3);
        obstacle_valid_in = '0;
        n = 0;
        while (immune_out === 1'b1 && n < 300) begin
`ifdef COLLISION_BLINK_EN
            exp_blink = ~n[BSH];
`else
            exp_blink = 1'b0;
`endif
            check("blink", 32'(blink_out), 32'(exp_blink));
            n++;
            tick();
        end
        check("immune_len", 32'(n), IMM);
        check("t1_hit_count", 32'(hit_count_out), 1);
        tick(5);

        // 2: touching edge does not hit, one pixel in does
        set_obst(0, 116, 100, 1'b1);
        tick(10);
        check("touch_no_hit", 32'(hit_count_out), 1);
        set_obst(0, 115, 100, 1'b1);
        expect_hit(0, 0);
        tick(3);
        obstacle_valid_in = '0;
        tick(IMM + 10);

        // 3: simultaneous overlap; invalid ch0 ignored, lowest valid (2) wins
        set_obst(0, 100, 100, 1'b0);
        set_obst(1, 500, 500, 1'b1);
        set_obst(2, 105, 105, 1'b1);
        set_obst(3, 95, 95, 1'b1);
        expect_hit(0, 2);
        tick(3);
        obstacle_valid_in = '0;
        tick(IMM + 10);
        check("t3_hit_count", 32'(hit_count_out), 3);

        // 4: continuous contact for 250 cycles: pulses at t, t+101, t+202
        set_obst(1, 100, 100, 1'b1);
        expect_hit(0, 1);
        expect_hit(IMM + 1, 1);
        expect_hit(2 * (IMM + 1), 1);
        tick(250);
        obstacle_valid_in = '0;
        tick(IMM);
        check("t4_hit_count", 32'(hit_count_out), 6);

        // 5: screen-edge boxes must not wrap; hold contact long enough to saturate
        mouse_x_in = 12'd4090;
        mouse_y_in = 12'd4090;
        set_obst(0, 4085, 4085, 1'b1);
        for (int k = 0; k < 252; k++) expect_hit(k * (IMM + 1), 0);
        tick(3 + 251 * (IMM + 1));
        obstacle_valid_in = '0;
        tick(IMM + 10);
        check("t5_saturated", 32'(hit_count_out), 255);

        // 6a: reset in the middle of the window
        mouse_x_in = 12'd100;
        mouse_y_in = 12'd100;
        set_obst(0, 110, 108, 1'b1);
        expect_hit(0, 0);
        tick(3);
        obstacle_valid_in = '0;
        tick(50);
        check("t6_pre_rst_immune", 32'(immune_out), 1);
        rst = 1'b1;
        tick();
        exp_count = 0;
        check("t6_rst_immune", 32'(immune_out), 0);
        check("t6_rst_hit_count", 32'(hit_count_out), 0);
        check("t6_rst_hit_id", 32'(hit_id_out), 0);
        check("t6_rst_blink", 32'(blink_out), 0);
        rst = 1'b0;
        tick(4);

        // 6b: enable dropped mid-window returns to IDLE with immunity cleared
        set_obst(3, 110, 108, 1'b1);
        expect_hit(0, 3);
        tick(3);
        obstacle_valid_in = '0;
        tick(20);
        check("t6_window_immune", 32'(immune_out), 1);
        enable_in = 1'b0;
        tick(3);
        check("t6_idle_immune", 32'(immune_out), 0);
        check("t6_idle_blink", 32'(blink_out), 0);
        check("t6_idle_hit_id", 32'(hit_id_out), 3);
        check("t6_idle_hit_count", 32'(hit_count_out), 1);
        tick(10);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
